// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu - arithmetic/logic unit with a single registered result stage.
//
// Combines two unsigned DATAWIDTH-bit operands under a 4-bit opcode. The
// result and its zero flag are captured on the next rising clock edge, so
// latency is one cycle and a new operation is accepted every cycle. The
// memory, jump, branch and load-immediate opcodes all use the adder, which
// lets the CPU use this block to compute addresses and targets.
//
// Ports:
//   clk       in   1          rising-edge clock
//   rst       in   1          synchronous active-high reset (out=0, zero=1)
//   a_i       in   DATAWIDTH  operand A (unsigned)
//   b_i       in   DATAWIDTH  operand B (unsigned)
//   opcode_i  in   4          operation select
//   out_o     out  DATAWIDTH  registered result
//   zero_o    out  1          registered flag, high when out_o is all zeros
// -----------------------------------------------------------------------------
module alu #(
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATAWIDTH-1:0] a_i,
   input  logic [DATAWIDTH-1:0] b_i,
   input  logic [3:0]           opcode_i,
   output logic [DATAWIDTH-1:0] out_o,
   output logic                 zero_o
);

   // Opcode encodings shared with the CPU decoder.
   localparam logic [3:0] ADD_OP = 4'd0;
   localparam logic [3:0] SUB_OP = 4'd1;
   localparam logic [3:0] MUL_OP = 4'd2;
   localparam logic [3:0] DIV_OP = 4'd3;
   localparam logic [3:0] AND_OP = 4'd4;
   localparam logic [3:0] OR_OP  = 4'd5;
   localparam logic [3:0] XOR_OP = 4'd6;
   localparam logic [3:0] LW_OP  = 4'd7;
   localparam logic [3:0] SW_OP  = 4'd8;
   localparam logic [3:0] JMP_OP = 4'd9;
   localparam logic [3:0] BEQ_OP = 4'd10;
   localparam logic [3:0] BGT_OP = 4'd11;
   localparam logic [3:0] BLT_OP = 4'd12;
   localparam logic [3:0] LI_OP  = 4'd13;

   logic [DATAWIDTH-1:0] sum;
   logic [DATAWIDTH-1:0] diff;
   logic [DATAWIDTH-1:0] prod;
   logic [DATAWIDTH-1:0] quot;
   logic [DATAWIDTH-1:0] out_d, out_q;
   logic                 zero_d, zero_q;

   // Arithmetic sub-path. All results are taken modulo 2^DATAWIDTH; the
   // multiplier keeps only the low half of the product.
   assign sum  = a_i + b_i;
   assign diff = a_i - b_i;
   assign prod = a_i * b_i;
   // Divide by zero saturates to all ones instead of trapping.
   assign quot = (b_i == '0) ? '1 : (a_i / b_i);

   always_comb begin
      out_d = '0;  // reserved opcodes 14/15 produce zero
      case (opcode_i)
         ADD_OP, LW_OP, SW_OP, JMP_OP,
         BEQ_OP, BGT_OP, BLT_OP, LI_OP: out_d = sum;
         SUB_OP:                         out_d = diff;
         MUL_OP:                         out_d = prod;
         DIV_OP:                         out_d = quot;
         AND_OP:                         out_d = a_i & b_i;
         OR_OP:                          out_d = a_i | b_i;
         XOR_OP:                         out_d = a_i ^ b_i;
         default:                        out_d = '0;
      endcase
      // Flag comes from the same value that gets registered.
      zero_d = (out_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         out_q  <= out_d;
         zero_q <= zero_d;
      end
   end

   assign out_o  = out_q;
   assign zero_o = zero_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu - table-driven directed vectors for alu plus hand-written sequences
// for reset hold and between-edge input changes.
// -----------------------------------------------------------------------------
module tb_alu;

   localparam int W = 32;

   typedef struct {
      string        name;
      logic         rst;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   op;
      logic [W-1:0] exp_out;
      logic         exp_zero;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a_i, b_i;
   logic [3:0]   opcode_i;
   logic [W-1:0] out_o;
   logic         zero_o;

   int n_vec = 0;
   int n_err = 0;
   vec_t vecs[$];

   alu #(.DATAWIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .a_i      (a_i),
      .b_i      (b_i),
      .opcode_i (opcode_i),
      .out_o    (out_o),
      .zero_o   (zero_o)
   );

   always #5 clk = ~clk;

   task automatic add_vec(input string name, input logic r, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [3:0] op,
                          input logic [W-1:0] eo, input logic ez);
      vec_t v;
      v.name = name; v.rst = r; v.a = a; v.b = b; v.op = op;
      v.exp_out = eo; v.exp_zero = ez;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [W-1:0] eo, input logic ez);
      n_vec++;
      if (out_o !== eo || zero_o !== ez) begin
         n_err++;
         $display("FAIL %s: got out=%h zero=%b, expected out=%h zero=%b",
                  name, out_o, zero_o, eo, ez);
      end
   endtask

   // Drive at the falling edge, check 1 time unit after the rising edge.
   task automatic apply(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op);
      @(negedge clk);
      rst = r; a_i = a; b_i = b; opcode_i = op;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; a_i = '0; b_i = '0; opcode_i = '0;

      // Reset then release.
      add_vec("reset_add",  1, 5, 7, 0, 0, 1);
      add_vec("first_add",  0, 5, 7, 0, 12, 0);
      // Opcode sweep with a=34, b=35.
      add_vec("sw_add", 0, 34, 35, 0,  69, 0);
      add_vec("sw_sub", 0, 34, 35, 1,  32'hFFFF_FFFF, 0);
      add_vec("sw_mul", 0, 34, 35, 2,  1190, 0);
      add_vec("sw_div", 0, 34, 35, 3,  0, 1);
      add_vec("sw_and", 0, 34, 35, 4,  34, 0);
      add_vec("sw_or",  0, 34, 35, 5,  35, 0);
      add_vec("sw_xor", 0, 34, 35, 6,  1, 0);
      add_vec("sw_lw",  0, 34, 35, 7,  69, 0);
      add_vec("sw_sw",  0, 34, 35, 8,  69, 0);
      add_vec("sw_jmp", 0, 34, 35, 9,  69, 0);
      add_vec("sw_beq", 0, 34, 35, 10, 69, 0);
      add_vec("sw_bgt", 0, 34, 35, 11, 69, 0);
      add_vec("sw_blt", 0, 34, 35, 12, 69, 0);
      add_vec("sw_li",  0, 34, 35, 13, 69, 0);
      // Wrap-around.
      add_vec("add_wrap", 0, 32'hFFFF_FFFF, 1, 0, 0, 1);
      add_vec("mul_wrap", 0, 32'h0001_0000, 32'h0001_0000, 2, 0, 1);
      add_vec("sub_wrap", 0, 0, 1, 1, 32'hFFFF_FFFF, 0);
      add_vec("sub_plain",0, 100, 7, 1, 93, 0);
      // Division.
      add_vec("div_100_7", 0, 100, 7, 3, 14, 0);
      add_vec("div_by0",   0, 100, 0, 3, 32'hFFFF_FFFF, 0);
      add_vec("div_0_0",   0, 0, 0, 3, 32'hFFFF_FFFF, 0);
      // Distinct bit patterns for the logic path.
      add_vec("and_pat", 0, 32'hF0F0, 32'h0FF0, 4, 32'h00F0, 0);
      add_vec("or_pat",  0, 32'hF0F0, 32'h0FF0, 5, 32'hFFF0, 0);
      add_vec("xor_pat", 0, 32'hF0F0, 32'h0FF0, 6, 32'hFF00, 0);
      // Reserved and back-to-back.
      add_vec("rsv14",   0, 3, 4, 14, 0, 1);
      add_vec("rsv15",   0, 3, 4, 15, 0, 1);
      add_vec("xor_a5",  0, 32'hA5, 32'hA5, 6, 0, 1);
      add_vec("or_a5",   0, 32'hA5, 32'hA5, 5, 32'hA5, 0);
      // Reset mid-stream during ADDs; reset also overrides DIV-by-zero.
      add_vec("ms_add1", 0, 1, 2, 0, 3, 0);
      add_vec("ms_rst",  1, 10, 20, 0, 0, 1);
      add_vec("ms_add2", 0, 10, 20, 0, 30, 0);
      add_vec("ms_rstdv",1, 9, 0, 3, 0, 1);
      add_vec("ms_div",  0, 9, 0, 3, 32'hFFFF_FFFF, 0);

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].op);
         check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_zero);
      end

      // Inputs changing between edges must not reach the outputs.
      apply(0, 1, 1, 0);
      check("hold_pre", 2, 0);
      @(negedge clk);
      a_i = 0; b_i = 1; opcode_i = 1;
      #2;
      check("hold_mid", 2, 0);
      @(posedge clk);
      #1;
      check("hold_post", 32'hFFFF_FFFF, 0);

      // Reset held across several edges with live inputs.
      for (int k = 0; k < 3; k++) begin
         apply(1, 40, 2, 0);
         check("rst_hold", 0, 1);
      end
      apply(0, 40, 2, 0);
      check("rst_release", 42, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Safety net: the run is purely clock-driven, but never let it hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
